rvc_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the core data port and an external

---
 rtl/rvc_mem_arbiter_pkg.sv | 34 +++
 rtl/rvc_mem_arbiter_rr.sv | 19 +
 rtl/rvc_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rvc_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rvc_mem_arbiter_pkg.sv
// Shared types and constants for the core/loader memory arbiter.
package rvc_mem_arbiter_pkg;

  localparam int ADDR_W        = 16;
  localparam int BURST_W       = 8;
  localparam int MAX_CORE_WAIT = 8;
  localparam int WAIT_W        = $clog2(MAX_CORE_WAIT + 1);

  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE      = 1'b0,
    LDR_BURST = 1'b1
  } t_mem_arb_state;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2
  } t_mem_owner;

  typedef struct packed {
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;
    logic [3:0]        byte_en;
  } t_mem_req;

  // A zero-length burst still moves one beat.
  function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] len);
    return (len == {BURST_W{1'b0}}) ? BURST_ONE : len;
  endfunction

endpackage

// File: rtl/rvc_mem_arbiter_rr.sv
// Two-way round-robin picker; bit 0 is the core, bit 1 the loader.
module rvc_mem_arbiter_rr (
  input  logic [1:0] req,
  input  logic       last_ldr,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_ldr ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rvc_mem_arbiter.sv
// Shares one single-port synchronous memory between the core data port and a
// loader/debug port: one access per cycle, round-robin, loader bursts with a core starvation guard.
module rvc_mem_arbiter
  import rvc_mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               core_req,
  input  logic               core_wr_en,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [31:0]        core_wr_data,
  input  logic [3:0]         core_byte_en,
  output logic               core_gnt,
  output logic               core_rd_valid,
  output logic [31:0]        core_rd_data,
  input  logic               ldr_req,
  input  logic               ldr_wr_en,
  input  logic [ADDR_W-1:0]  ldr_addr,
  input  logic [31:0]        ldr_wr_data,
  input  logic [3:0]         ldr_byte_en,
  input  logic [BURST_W-1:0] ldr_burst_len,
  output logic               ldr_gnt,
  output logic               ldr_rd_valid,
  output logic [31:0]        ldr_rd_data,
  output logic               mem_en,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wr_data,
  output logic [3:0]         mem_byte_en,
  input  logic [31:0]        mem_rd_data
);

  t_mem_arb_state     state_r;
  logic               last_ldr_r;
  logic [BURST_W-1:0] burst_cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  t_mem_owner         owner_r;

  logic [1:0]         rr_gnt_s;
  logic               core_gnt_s;
  logic               ldr_gnt_s;
  logic               force_core_s;
  logic [BURST_W-1:0] len_s;
  t_mem_req           core_cmd_s;
  t_mem_req           ldr_cmd_s;
  t_mem_req           win_cmd_s;

  rvc_mem_arbiter_rr u_rr (
    .req      ({ldr_req, core_req}),
    .last_ldr (last_ldr_r),
    .gnt      (rr_gnt_s)
  );

  assign core_cmd_s = '{wr_en: core_wr_en, addr: core_addr, wr_data: core_wr_data, byte_en: core_byte_en};
  assign ldr_cmd_s  = '{wr_en: ldr_wr_en,  addr: ldr_addr,  wr_data: ldr_wr_data,  byte_en: ldr_byte_en};
  assign len_s      = eff_len(ldr_burst_len);

  // Grant decision: round-robin when idle, loader-locked during a burst unless the core has starved.
  always_comb begin
    core_gnt_s   = 1'b0;
    ldr_gnt_s    = 1'b0;
    force_core_s = core_req && (wait_cnt_r == WAIT_W'(MAX_CORE_WAIT));
    case (state_r)
      IDLE: begin
        core_gnt_s = rr_gnt_s[0];
        ldr_gnt_s  = rr_gnt_s[1];
      end
      LDR_BURST: begin
        if (ldr_req && !force_core_s) begin
          ldr_gnt_s = 1'b1;
        end else if (core_req) begin
          core_gnt_s = 1'b1;
        end else begin
          core_gnt_s = 1'b0;
          ldr_gnt_s  = 1'b0;
        end
      end
      default: begin
        core_gnt_s = 1'b0;
        ldr_gnt_s  = 1'b0;
      end
    endcase
  end

  // Memory command follows the winner; quiet bus when nobody is granted.
  always_comb begin
    win_cmd_s = '0;
    if (ldr_gnt_s) begin
      win_cmd_s = ldr_cmd_s;
    end else if (core_gnt_s) begin
      win_cmd_s = core_cmd_s;
    end else begin
      win_cmd_s = '0;
    end
  end

  assign core_gnt    = core_gnt_s;
  assign ldr_gnt     = ldr_gnt_s;
  assign mem_en      = core_gnt_s | ldr_gnt_s;
  assign mem_wr_en   = win_cmd_s.wr_en;
  assign mem_addr    = win_cmd_s.addr;
  assign mem_wr_data = win_cmd_s.wr_data;
  assign mem_byte_en = win_cmd_s.byte_en;

  assign core_rd_valid = (owner_r == OWN_CORE);
  assign ldr_rd_valid  = (owner_r == OWN_LDR);
  assign core_rd_data  = core_rd_valid ? mem_rd_data : 32'h0000_0000;
  assign ldr_rd_data   = ldr_rd_valid  ? mem_rd_data : 32'h0000_0000;

  // Arbiter FSM, burst/wait counters and read-response owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_ldr_r  <= 1'b1;
      burst_cnt_r <= {BURST_W{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
      owner_r     <= OWN_NONE;
    end else begin
      if (core_gnt_s && !core_wr_en) begin
        owner_r <= OWN_CORE;
      end else if (ldr_gnt_s && !ldr_wr_en) begin
        owner_r <= OWN_LDR;
      end else begin
        owner_r <= OWN_NONE;
      end

      case (state_r)
        IDLE: begin
          wait_cnt_r <= {WAIT_W{1'b0}};
          if (ldr_gnt_s) begin
            last_ldr_r <= 1'b1;
            if (len_s > BURST_ONE) begin
              state_r     <= LDR_BURST;
              burst_cnt_r <= len_s - BURST_ONE;
            end else begin
              state_r     <= IDLE;
              burst_cnt_r <= {BURST_W{1'b0}};
            end
          end else if (core_gnt_s) begin
            last_ldr_r <= 1'b0;
          end else begin
            last_ldr_r <= last_ldr_r;
          end
        end
        LDR_BURST: begin
          if (ldr_gnt_s) begin
            burst_cnt_r <= burst_cnt_r - BURST_ONE;
            if (burst_cnt_r == BURST_ONE) begin
              state_r    <= IDLE;
              last_ldr_r <= 1'b1;
              wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (core_req && (wait_cnt_r != WAIT_W'(MAX_CORE_WAIT))) begin
              wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
              wait_cnt_r <= wait_cnt_r;
            end
          end else if (core_gnt_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_mem_arbiter.sv
// Directed self-checking bench for rvc_mem_arbiter.
module tb_rvc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_wr_en;
  logic [15:0] core_addr;
  logic [31:0] core_wr_data;
  logic [3:0]  core_byte_en;
  logic        core_gnt, core_rd_valid;
  logic [31:0] core_rd_data;
  logic        ldr_req, ldr_wr_en;
  logic [15:0] ldr_addr;
  logic [31:0] ldr_wr_data;
  logic [3:0]  ldr_byte_en;
  logic [7:0]  ldr_burst_len;
  logic        ldr_gnt, ldr_rd_valid;
  logic [31:0] ldr_rd_data;
  logic        mem_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int ldr_beats;

  always #5 clk = ~clk;

  rvc_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_byte_en(core_byte_en),
    .core_gnt(core_gnt), .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
    .ldr_req(ldr_req), .ldr_wr_en(ldr_wr_en), .ldr_addr(ldr_addr),
    .ldr_wr_data(ldr_wr_data), .ldr_byte_en(ldr_byte_en), .ldr_burst_len(ldr_burst_len),
    .ldr_gnt(ldr_gnt), .ldr_rd_valid(ldr_rd_valid), .ldr_rd_data(ldr_rd_data),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; ldr_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    check("rst_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_core_rdv", {31'd0, core_rd_valid}, 32'd0);
    check("rst_ldr_rdv", {31'd0, ldr_rd_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    core_wr_en = 1'b0; core_addr = 16'h0; core_wr_data = 32'h0; core_byte_en = 4'hF;
    ldr_wr_en = 1'b0; ldr_addr = 16'h0; ldr_wr_data = 32'h0; ldr_byte_en = 4'hF;
    ldr_burst_len = 8'd1; mem_rd_data = 32'hA5A5_A5A5;
    do_reset();

    // 1: core load, response one cycle later on the core port only
    core_req = 1'b1; core_wr_en = 1'b0; core_addr = 16'h0100;
    #1;
    check("t1_core_gnt", {31'd0, core_gnt}, 32'd1);
    check("t1_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
    check("t1_mem_en", {31'd0, mem_en}, 32'd1);
    check("t1_mem_wr", {31'd0, mem_wr_en}, 32'd0);
    check("t1_mem_addr", {16'd0, mem_addr}, 32'h0000_0100);
    tick();
    core_req = 1'b0; mem_rd_data = 32'hDEAD_BEEF;
    #1;
    check("t1_core_rdv", {31'd0, core_rd_valid}, 32'd1);
    check("t1_core_rdd", core_rd_data, 32'hDEAD_BEEF);
    check("t1_ldr_rdv", {31'd0, ldr_rd_valid}, 32'd0);
    check("t1_ldr_rdd", ldr_rd_data, 32'h0);
    tick();
    check("t1_core_rdv_off", {31'd0, core_rd_valid}, 32'd0);
    check("t1_core_rdd_off", core_rd_data, 32'h0);

    // 2: both single-beat writers from reset alternate, core first
    do_reset();
    core_req = 1'b1; core_wr_en = 1'b1; core_addr = 16'h0010;
    ldr_req = 1'b1; ldr_wr_en = 1'b1; ldr_addr = 16'h0020; ldr_burst_len = 8'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_core_gnt", {31'd0, core_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_ldr_gnt", {31'd0, ldr_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("t2_mem_addr", {16'd0, mem_addr}, (i % 2 == 0) ? 32'h10 : 32'h20);
      tick();
    end
    idle_inputs();

    // 3: loader write burst of 4, then IDLE again (tie goes to core since loader won last)
    ldr_req = 1'b1; ldr_burst_len = 8'd4; ldr_wr_data = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_ldr_gnt", {31'd0, ldr_gnt}, 32'd1);
      check("t3_mem_wr", {31'd0, mem_wr_en}, 32'd1);
      check("t3_mem_wdata", mem_wr_data, 32'h1111_2222);
      tick();
    end
    core_req = 1'b1;
    #1;
    check("t3_after_core_gnt", {31'd0, core_gnt}, 32'd1);
    check("t3_after_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
    tick();
    idle_inputs();

    // 4: loader burst of 20, core waits 8 beats then is forced in
    ldr_req = 1'b1; ldr_burst_len = 8'd20; ldr_beats = 0;
    for (int c = 0; c <= 20; c++) begin
      core_req = (c >= 1 && c <= 9);
      #1;
      check("t4_core_gnt", {31'd0, core_gnt}, (c == 9) ? 32'd1 : 32'd0);
      check("t4_ldr_gnt", {31'd0, ldr_gnt}, (c == 9) ? 32'd0 : 32'd1);
      if (ldr_gnt) ldr_beats++;
      tick();
    end
    check("t4_ldr_beats", ldr_beats, 32'd20);
    ldr_req = 1'b0; core_req = 1'b0;
    #1;
    check("t4_idle_mem_en", {31'd0, mem_en}, 32'd0);
    tick();

    // 5: length 0 means one beat; loader read data goes to loader port only
    ldr_req = 1'b1; ldr_wr_en = 1'b0; ldr_addr = 16'h0040; ldr_burst_len = 8'd0;
    #1;
    check("t5_ldr_gnt", {31'd0, ldr_gnt}, 32'd1);
    tick();
    mem_rd_data = 32'h1234_5678; core_req = 1'b1; core_wr_en = 1'b1;
    #1;
    check("t5_ldr_rdv", {31'd0, ldr_rd_valid}, 32'd1);
    check("t5_ldr_rdd", ldr_rd_data, 32'h1234_5678);
    check("t5_core_rdv", {31'd0, core_rd_valid}, 32'd0);
    check("t5_core_rdd", core_rd_data, 32'h0);
    check("t5_no_burst_core_gnt", {31'd0, core_gnt}, 32'd1);
    check("t5_no_burst_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
    tick();
    idle_inputs();

    // 6: reset in the middle of a read burst drops everything
    ldr_req = 1'b1; ldr_wr_en = 1'b0; ldr_burst_len = 8'd10;
    tick(); tick(); tick();
    check("t6_pending_rdv", {31'd0, ldr_rd_valid}, 32'd1);
    ldr_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ldr_rdv", {31'd0, ldr_rd_valid}, 32'd0);
    check("t6_rst_ldr_rdd", ldr_rd_data, 32'h0);
    check("t6_rst_core_rdv", {31'd0, core_rd_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    core_req = 1'b1; ldr_req = 1'b1; core_wr_en = 1'b1; ldr_burst_len = 8'd1;
    #1;
    check("t6_tie_core_gnt", {31'd0, core_gnt}, 32'd1);
    check("t6_tie_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
    tick();
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
